// File: rtl/instr_issuer.sv
// instr_issuer: issues a buffered program of 16-bit instructions to a CPU,
// one instruction at a time, using a load / start / wait handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   prog_we    program buffer write strobe (ignored while busy)
//   prog_addr  program buffer write address
//   prog_data  instruction word to write
//   prog_len   number of instructions to issue (clamped to DEPTH), sampled on go
//   go         start pulse (ignored while busy)
//   abort      stop a run in progress (sets err, no done pulse)
//   cpu_w      CPU ready flag (1 = idle/ready)
//   cpu_in     instruction word to the CPU (held while idle)
//   cpu_load   CPU instruction-register load strobe
//   cpu_s      CPU start strobe
//   busy       run in progress
//   done       one-cycle pulse on run completion
//   err        sticky error flag, cleared by go
//   pc         index of the instruction being issued
//
// Optional feature: define ISSUER_TIMEOUT_EN to add a watchdog on the two
// wait states; on expiry err is set and the run finishes with a done pulse.
`timescale 1ns/1ps

module instr_issuer #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [15:0]                prog_data,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       go,
  input  logic                       abort,
  input  logic                       cpu_w,
  output logic [15:0]                cpu_in,
  output logic                       cpu_load,
  output logic                       cpu_s,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH)-1:0]   pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_LO, WAIT_HI, NEXT, FIN
  } state_t;

  state_t          state;
  logic [LW-1:0]   len;
  logic [LW-1:0]   len_in;
  logic [AW-1:0]   pc_inc;
  logic            last;
  logic [15:0]     mem [DEPTH];

`ifdef ISSUER_TIMEOUT_EN
  localparam int unsigned WDW = 8;
  logic [WDW-1:0]  wdog;
`else
  logic            unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  // Program buffer: no reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  // Length clamp and end-of-program detection.
  always_comb begin
    len_in = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    pc_inc = AW'(pc + 1'b1);
    last   = (({1'b0, pc} + LW'(1)) == len);
  end

  // Issue FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      len      <= '0;
      cpu_in   <= '0;
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pc       <= '0;
`ifdef ISSUER_TIMEOUT_EN
      wdog     <= '0;
`endif
    end else begin
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && abort) begin
        err   <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              len  <= len_in;
              pc   <= '0;
              err  <= 1'b0;
              busy <= 1'b1;
              if (len_in != '0) begin
                state    <= LOAD;
                cpu_load <= 1'b1;
                cpu_in   <= mem[0];
              end else begin
                state <= FIN;
              end
            end
          end
          LOAD: begin
            state <= START;
            cpu_s <= 1'b1;
          end
          START: begin
            state <= WAIT_LO;
`ifdef ISSUER_TIMEOUT_EN
            wdog  <= '0;
`endif
          end
          // Wait for cpu_w to drop so a stale ready is never taken.
          WAIT_LO: begin
            if (!cpu_w) begin
              state <= WAIT_HI;
`ifdef ISSUER_TIMEOUT_EN
              wdog  <= '0;
            end else if (wdog == WDW'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= FIN;
            end else begin
              wdog  <= wdog + WDW'(1);
`endif
            end
          end
          WAIT_HI: begin
            if (cpu_w) begin
              state <= NEXT;
`ifdef ISSUER_TIMEOUT_EN
            end else if (wdog == WDW'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= FIN;
            end else begin
              wdog  <= wdog + WDW'(1);
`endif
            end
          end
          NEXT: begin
            if (last) begin
              state <= FIN;
            end else begin
              pc       <= pc_inc;
              cpu_in   <= mem[pc_inc];
              cpu_load <= 1'b1;
              state    <= LOAD;
            end
          end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer with a small CPU model stepped on the
// falling edge in the same process as the stimulus.
`timescale 1ns/1ps

module tb_instr_issuer;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [5:0]  prog_len;
  logic        go;
  logic        abort;
  logic        cpu_w;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  pc;

  instr_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .go        (go),
    .abort     (abort),
    .cpu_w     (cpu_w),
    .cpu_in    (cpu_in),
    .cpu_load  (cpu_load),
    .cpu_s     (cpu_s),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          errors;
  int          cyc;
  int          loads;
  int          starts;
  int          dones;
  int          cnt;
  int          cpu_lat;
  bit          cpu_stuck;
  logic [15:0] ir;
  logic [15:0] r [16];
  int          pc_log [$];
  logic [15:0] ir_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance to the falling edge, then step the CPU model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (done) dones++;
    if (cpu_load) begin
      ir = cpu_in;
      loads++;
      pc_log.push_back(int'(pc));
      ir_log.push_back(cpu_in);
    end
    if (cpu_s) begin
      starts++;
      if (!cpu_stuck) begin
        case (ir[15:12])
          4'hD: r[ir[11:8]] = {8'h00, ir[7:0]};
          4'hA: r[ir[7:5]]  = r[ir[11:8]] * {12'h000, ir[3:0]};
          default: ;
        endcase
        cnt   = cpu_lat;
        cpu_w = 1'b0;
      end
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) cpu_w = 1'b1;
    end
  endtask

  task automatic model_clear();
    loads  = 0;
    starts = 0;
    cnt    = 0;
    cpu_w  = 1'b1;
    pc_log.delete();
    ir_log.delete();
    for (int i = 0; i < 16; i++) r[i] = 16'hDEAD;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go_run(input logic [5:0] n);
    prog_len = n;
    go       = 1'b1;
    tick();
    go       = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    int d0;
    d0 = dones;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (dones != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reach WAIT_HI of the instruction at index idx; returns found flag.
  task automatic reach_wait_hi(input logic [4:0] idx, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cpu_s && pc == idx) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  initial begin
    bit ok;
    int d0;
    int c0;

    vectors   = 0;
    errors    = 0;
    cyc       = 0;
    dones     = 0;
    cpu_lat   = 4;
    cpu_stuck = 1'b0;
    ir        = '0;
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    go        = 1'b0;
    abort     = 1'b0;
    model_clear();

    // Reset values before any clock edge.
    #1;
    chk("rst_outs", 32'({cpu_in, cpu_load, cpu_s, busy, done, err, pc}), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Three-instruction program.
    wr(5'd0, 16'hD007);
    wr(5'd1, 16'hD102);
    wr(5'd2, 16'hA148);
    model_clear();
    go_run(6'd3);
    chk("run3_first_load", 32'({cpu_load, busy, cpu_in, pc}), 32'({1'b1, 1'b1, 16'hD007, 5'd0}));
    wait_done(300, ok);
    chk("run3_done", 32'(ok), 32'h1);
    chk("run3_loads", 32'(loads), 32'd3);
    chk("run3_starts", 32'(starts), 32'd3);
    chk("run3_pcseq", 32'({8'(pc_log[0]), 8'(pc_log[1]), 8'(pc_log[2])}), 32'h000102);
    chk("run3_r0", 32'(r[0]), 32'h7);
    chk("run3_r1", 32'(r[1]), 32'h2);
    chk("run3_r2", 32'(r[2]), 32'h10);
    chk("run3_err", 32'(err), 32'h0);
    tick();
    chk("run3_done_1cyc", 32'(done), 32'h0);
    tick();
    tick();
    chk("idle_hold", 32'({busy, cpu_in}), 32'({1'b0, 16'hA148}));

    // Zero-length program.
    model_clear();
    d0 = dones;
    go_run(6'd0);
    chk("len0_c1", 32'({done, busy}), 32'b01);
    tick();
    chk("len0_c2", 32'({done, busy}), 32'b10);
    chk("len0_noload", 32'(loads), 32'd0);
    chk("len0_onedone", 32'(dones - d0), 32'd1);

    // cpu_w held high: stale ready must never be taken.
    model_clear();
    cpu_stuck = 1'b1;
    d0 = dones;
    c0 = cyc;
    go_run(6'd1);
`ifdef ISSUER_TIMEOUT_EN
    wait_done(400, ok);
    chk("wdog_done", 32'(ok), 32'h1);
    chk("wdog_err", 32'(err), 32'h1);
    chk("wdog_time", 32'((cyc - c0) >= 255 && (cyc - c0) <= 265), 32'h1);
`else
    repeat (300) tick();
    chk("stale_busy", 32'(busy), 32'h1);
    chk("stale_nodone", 32'(dones - d0), 32'd0);
    chk("stale_loads", 32'(loads), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("stale_abort", 32'({err, busy}), 32'b10);
`endif
    cpu_stuck = 1'b0;

    // go and prog_we during WAIT_HI are ignored.
    model_clear();
    cpu_lat = 10;
    go_run(6'd3);
    chk("go_clears_err", 32'(err), 32'h0);
    reach_wait_hi(5'd1, ok);
    chk("ign_reach", 32'({ok, cpu_w, busy}), 32'b101);
    go        = 1'b1;
    prog_len  = 6'd1;
    prog_we   = 1'b1;
    prog_addr = 5'd2;
    prog_data = 16'hFFFF;
    tick();
    go        = 1'b0;
    prog_we   = 1'b0;
    wait_done(300, ok);
    chk("ign_done", 32'(ok), 32'h1);
    chk("ign_loads", 32'(loads), 32'd3);
    chk("ign_pcseq", 32'({8'(pc_log[0]), 8'(pc_log[1]), 8'(pc_log[2])}), 32'h000102);
    chk("ign_word2", 32'(ir_log[2]), 32'hA148);
    chk("ign_r2", 32'(r[2]), 32'h10);

    // Abort in WAIT_HI of the second instruction.
    model_clear();
    go_run(6'd3);
    reach_wait_hi(5'd1, ok);
    chk("abt_reach", 32'(ok), 32'h1);
    d0 = dones;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_state", 32'({err, busy, cpu_load, cpu_s}), 32'b1000);
    repeat (20) tick();
    chk("abt_nodone", 32'(dones - d0), 32'd0);
    chk("abt_loads", 32'(loads), 32'd2);

    // Asynchronous reset during START.
    model_clear();
    cpu_lat = 4;
    go_run(6'd3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("rstmid_start", 32'({ok, pc}), 32'({1'b1, 5'd0}));
    d0 = dones;
    #1 reset = 1'b0;
    #1;
    chk("rstmid_outs", 32'({cpu_in, cpu_load, cpu_s, busy, done, err, pc}), 32'h0);
    tick();
    reset = 1'b1;
    cnt   = 0;
    cpu_w = 1'b1;
    tick();
    chk("rstmid_nodone", 32'(dones - d0), 32'd0);
    model_clear();
    go_run(6'd3);
    chk("rstmid_rerun", 32'({cpu_load, cpu_in, pc}), 32'({1'b1, 16'hD007, 5'd0}));
    wait_done(300, ok);
    chk("rstmid_rerun_done", 32'({ok, err}), 32'b10);
    chk("rstmid_rerun_r2", 32'(r[2]), 32'h10);

    // Full buffer with prog_len above DEPTH: clamps to 32, stops at pc 31.
    for (int k = 0; k < 32; k++) wr(5'(k), 16'hD000 | 16'(k));
    model_clear();
    cpu_lat = 2;
    go_run(6'd40);
    wait_done(1000, ok);
    chk("full_done", 32'(ok), 32'h1);
    chk("full_loads", 32'(loads), 32'd32);
    chk("full_last_pc", 32'(pc_log[pc_log.size() - 1]), 32'd31);
    chk("full_r0", 32'(r[0]), 32'd31);
    chk("full_err", 32'(err), 32'h0);
    tick();
    chk("full_hold", 32'({busy, cpu_in}), 32'({1'b0, 16'hD01F}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
